multdiv_sequencer: RTL and testbench

- Multicycle signed 32-bit multiplier/divider that sits beside the combinational ALU.
- Owns an FSM, an iteration counter and shared accumulator/shift registers.
- Sequences one radix-2 iteration per clock: shift-add for multiply, restoring subtract for divide.
- Performs final two's-complement sign correction with the 32-bit bitwise-invert stage plus increment.

---
 rtl/multdiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - multicycle signed 32-bit multiply/divide sequencer
// Radix-2 shift-add multiply and restoring divide on a shared 64-bit register.
module multdiv_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        op_mult_q, op_mult_d;
   logic        sign_q, sign_d;
   logic [31:0] oper_q, oper_d;
   logic [63:0] prod_q, prod_d;
   logic        div_zero_q, div_zero_d;
   logic        div_ovf_q, div_ovf_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;

   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum;
   logic [63:0] div_sh;
   logic [32:0] div_diff;
   logic [31:0] mag, mag_neg, signed_res;
   logic        mult_ovf;
   logic        start;

   assign start = ctrl_MULT | ctrl_DIV;
   assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
   assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

   // Multiply: mplr sits in the low half; the adder carry becomes the new bit 63.
   assign mul_sum = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? oper_q : 32'd0)};

   // Divide: remainder stays below |B| <= 2^31, so 32 bits hold it after the shift.
   assign div_sh   = {prod_q[62:0], 1'b0};
   assign div_diff = {1'b0, div_sh[63:32]} - {1'b0, oper_q};

   assign mag        = prod_q[31:0];
   assign mag_neg    = ~mag + 32'd1;
   assign signed_res = sign_q ? mag_neg : mag;

   // A negative result may reach magnitude 2^31; a positive one only 2^31-1.
   always_comb begin
      mult_ovf = 1'b0;
      if (sign_q) begin
         mult_ovf = (|prod_q[63:32]) || (prod_q[31:0] > 32'h8000_0000);
      end else begin
         mult_ovf = |prod_q[63:31];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_mult_d  = op_mult_q;
      sign_d     = sign_q;
      oper_d     = oper_q;
      prod_d     = prod_q;
      div_zero_d = div_zero_q;
      div_ovf_d  = div_ovf_q;
      result_d   = result_q;
      exc_d      = exc_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_RUN: begin
            cnt_d = cnt_q + 5'd1;
            if (op_mult_q) begin
               prod_d = {mul_sum, prod_q[31:1]};
            end else if (div_diff[32]) begin
               prod_d = div_sh;
            end else begin
               prod_d = {div_diff[31:0], div_sh[31:1], 1'b1};
            end
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (op_mult_q) begin
               result_d = signed_res;
               exc_d    = mult_ovf;
            end else if (div_zero_q) begin
               result_d = 32'd0;
               exc_d    = 1'b1;
            end else if (div_ovf_q) begin
               result_d = 32'h8000_0000;
               exc_d    = 1'b1;
            end else begin
               result_d = signed_res;
               exc_d    = 1'b0;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A start in any state aborts whatever is in flight, including a pending FIX load.
      if (start) begin
         op_mult_d  = ctrl_MULT;
         sign_d     = data_operandA[31] ^ data_operandB[31];
         oper_d     = ctrl_MULT ? abs_a : abs_b;
         prod_d     = {32'd0, (ctrl_MULT ? abs_b : abs_a)};
         div_zero_d = (data_operandB == 32'd0);
         div_ovf_d  = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
         cnt_d      = 5'd0;
         result_d   = result_q;
         exc_d      = exc_q;
         state_d    = S_RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 5'd0;
         op_mult_q  <= 1'b0;
         sign_q     <= 1'b0;
         oper_q     <= 32'd0;
         prod_q     <= 64'd0;
         div_zero_q <= 1'b0;
         div_ovf_q  <= 1'b0;
         result_q   <= 32'd0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_mult_q  <= op_mult_d;
         sign_q     <= sign_d;
         oper_q     <= oper_d;
         prod_q     <= prod_d;
         div_zero_q <= div_zero_d;
         div_ovf_q  <= div_ovf_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == S_DONE);
   assign busy           = (state_q == S_RUN) || (state_q == S_FIX);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
// Directed vector table, restart/reset sequences, and random ops against an arithmetic model.
module tb_multdiv_sequencer;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_cmp;
   int n_bad;

   multdiv_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        m;
      logic        d;
      logic [31:0] exp_res;
      logic        exp_exc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain signed arithmetic on the true operands.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic m,
                        output logic [31:0] res, output logic exc);
      logic signed [63:0] sa, sb, p;
      int ia, ib;
      if (m) begin
         sa  = {{32{a[31]}}, a};
         sb  = {{32{b[31]}}, b};
         p   = sa * sb;
         res = p[31:0];
         exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         res = 32'd0;
         exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res = 32'h8000_0000;
         exc = 1'b1;
      end else begin
         ia  = int'(a);
         ib  = int'(b);
         res = 32'(ia / ib);
         exc = 1'b0;
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Observes 40 cycles after a start edge; n counts negedges after that edge.
   task automatic watch(output int lat, output int pulses, output logic [31:0] res,
                        output logic exc, output logic busy_ok, output logic hold_ok);
      logic [31:0] r0;
      logic        e0;
      r0 = data_result;
      e0 = data_exception;
      lat = 0; pulses = 0; res = 32'd0; exc = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (data_resultRDY) begin
            pulses++;
            if (lat == 0) begin
               lat = n;
               res = data_result;
               exc = data_exception;
            end
         end else if (lat == 0 && (data_result !== r0 || data_exception !== e0)) begin
            hold_ok = 1'b0;
         end
         if (busy !== (n <= 33)) busy_ok = 1'b0;
      end
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic d,
                            input logic [31:0] exp_res, input logic exp_exc, input logic full);
      int lat, pulses;
      logic [31:0] res;
      logic exc, busy_ok, hold_ok;
      start(a, b, m, d);
      watch(lat, pulses, res, exc, busy_ok, hold_ok);
      chk({tag, " result"}, res, exp_res);
      chk({tag, " exception"}, 32'(exc), 32'(exp_exc));
      chk({tag, " rdy pulses"}, 32'(pulses), 32'd1);
      if (full) begin
         chk({tag, " rdy latency"}, 32'(lat), 32'd34);
         chk({tag, " busy window"}, 32'(busy_ok), 32'd1);
         chk({tag, " result hold"}, 32'(hold_ok), 32'd1);
      end
   endtask

   vec_t vecs[$];

   initial begin
      int lat, pulses;
      logic [31:0] res, er;
      logic exc, ee, busy_ok, hold_ok;
      logic [31:0] ra, rb;
      logic rm;

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;

      vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0});
      vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 1'b0});
      vecs.push_back('{32'hFFFF_FFD6, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0});
      vecs.push_back('{32'h0000_0064, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1});
      vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1});
      vecs.push_back('{32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_001B, 1'b0});
      vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0000, 1'b0});
      vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1});
      vecs.push_back('{32'h4000_0000, 32'h0000_0002, 1'b1, 1'b0, 32'h8000_0000, 1'b1});
      vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{32'h0000_0000, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b0});

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset result", data_result, 32'd0);
      chk("reset exception", 32'(data_exception), 32'd0);
      chk("reset rdy", 32'(data_resultRDY), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].d,
                   vecs[i].exp_res, vecs[i].exp_exc, 1'b1);
      end

      // Restart: DIV 20/4 at E10 aborts MULT 3x4.
      start(32'd3, 32'd4, 1'b1, 1'b0);
      repeat (9) @(negedge clock);
      start(32'd20, 32'd4, 1'b0, 1'b1);
      watch(lat, pulses, res, exc, busy_ok, hold_ok);
      chk("restart result", res, 32'd5);
      chk("restart exception", 32'(exc), 32'd0);
      chk("restart rdy pulses", 32'(pulses), 32'd1);
      chk("restart latency", 32'(lat), 32'd34);
      chk("restart hold", 32'(hold_ok), 32'd1);

      // Reset sampled at E15 of a multiply.
      start(32'h0000_1234, 32'h0000_0056, 1'b1, 1'b0);
      repeat (14) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midreset result", data_result, 32'd0);
      chk("midreset exception", 32'(data_exception), 32'd0);
      chk("midreset rdy", 32'(data_resultRDY), 32'd0);
      chk("midreset busy", 32'(busy), 32'd0);
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (data_resultRDY) pulses++;
      end
      chk("midreset no rdy", 32'(pulses), 32'd0);
      run_check("post-reset", 32'hFFFF_FFFD, 32'h0000_000B, 1'b1, 1'b0, 32'hFFFF_FFDF, 1'b0, 1'b1);

      // Random operations versus the arithmetic model.
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = 32'($signed(16'($urandom))); rb = 32'($signed(16'($urandom))); end
            2: begin ra = $urandom; rb = 32'($urandom_range(0, 7)) - 32'd3; end
            default: begin ra = 32'($signed(8'($urandom))); rb = $urandom; end
         endcase
         rm = 1'($urandom_range(0, 1));
         model(ra, rb, rm, er, ee);
         run_check($sformatf("rnd%0d %s %h %h", k, rm ? "mul" : "div", ra, rb),
                   ra, rb, rm, ~rm, er, ee, (k % 10) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
